// File: rtl/cpu_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate formats and
// the register index width used by the decode/issue stage and its models.
package cpu_pkg;

  localparam int RW = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I classifier: immediate format, sign-extended immediate,
// which source registers are read and whether a non-x0 rd is written.
module imm_gen
  import cpu_pkg::*;
#(
  parameter int regSize = 32
) (
  input  logic [31:0]        instr,
  output imm_fmt_e           fmt,
  output logic [regSize-1:0] imm,
  output logic               uses_rs1,
  output logic               uses_rs2,
  output logic               writes_rd
);

  logic [31:0] imm32;

  always_comb begin
    fmt       = FMT_NONE;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (instr[6:0])
      OP_LUI, OP_AUIPC: begin
        fmt       = FMT_U;
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        fmt       = FMT_J;
        writes_rd = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        fmt       = FMT_I;
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_STORE: begin
        fmt      = FMT_S;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        fmt      = FMT_B;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_REG: begin
        fmt       = FMT_R;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
    // Writing x0 is architecturally a no-op, so it must never occupy the scoreboard.
    if (instr[11:7] == 5'd0) writes_rd = 1'b0;
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = regSize'($signed(imm32));

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: reads operands from the register file, stalls on RAW
// hazards tracked by a pending-write scoreboard and feeds the ID/EX register.
module decode_issue_stage #(
  parameter  int regNum    = 32,
  parameter  int regSize   = 32,
  parameter  int instrSize = 32,
  localparam int RW        = $clog2(regNum)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic [instrSize-1:0] if_instr,
  input  logic [regSize-1:0]   if_pc,
  output logic                 if_ready,
  output logic [RW-1:0]        rf_read_reg_1,
  output logic [RW-1:0]        rf_read_reg_2,
  input  logic [regSize-1:0]   rf_rd1,
  input  logic [regSize-1:0]   rf_rd2,
  input  logic                 wb_valid,
  input  logic [RW-1:0]        wb_reg,
  input  logic                 flush,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [regSize-1:0]   ex_pc,
  output logic [regSize-1:0]   ex_rs1_val,
  output logic [regSize-1:0]   ex_rs2_val,
  output logic [regSize-1:0]   ex_imm,
  output logic [RW-1:0]        ex_rd,
  output logic [6:0]           ex_opcode,
  output logic [2:0]           ex_funct3,
  output logic [6:0]           ex_funct7,
  output logic                 ex_writes_rd
);
  import cpu_pkg::*;

  logic [RW-1:0]      rs1, rs2, rd;
  imm_fmt_e           dec_fmt;
  logic [regSize-1:0] dec_imm;
  logic               dec_uses_rs1, dec_uses_rs2, dec_writes_rd;
  logic [regNum-1:0]  sb, sb_next;
  logic               hazard, accept;

  assign rs1 = RW'(if_instr[19:15]);
  assign rs2 = RW'(if_instr[24:20]);
  assign rd  = RW'(if_instr[11:7]);
  assign rf_read_reg_1 = rs1;
  assign rf_read_reg_2 = rs2;

  imm_gen #(.regSize(regSize)) u_imm_gen (
    .instr     (if_instr),
    .fmt       (dec_fmt),
    .imm       (dec_imm),
    .uses_rs1  (dec_uses_rs1),
    .uses_rs2  (dec_uses_rs2),
    .writes_rd (dec_writes_rd)
  );

  always_comb begin
    if (dec_fmt == FMT_NONE) assert (!dec_uses_rs1 && !dec_uses_rs2 && !dec_writes_rd);
  end

  assign hazard = (dec_uses_rs1 && (rs1 != '0) && sb[rs1]) ||
                  (dec_uses_rs2 && (rs2 != '0) && sb[rs2]);
  assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;

  // Clears are applied before the set so a same-edge set of one index wins.
  always_comb begin
    sb_next = sb;
    if (wb_valid && (wb_reg != '0)) sb_next[wb_reg] = 1'b0;
    if (flush && ex_valid && !ex_ready && ex_writes_rd) sb_next[ex_rd] = 1'b0;
    if (accept && dec_writes_rd) sb_next[rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb <= '0;
    else     sb <= sb_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7    <= '0;
      ex_writes_rd <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_rs1_val   <= rf_rd1;
      ex_rs2_val   <= rf_rd2;
      ex_imm       <= dec_imm;
      ex_rd        <= rd;
      ex_opcode    <= if_instr[6:0];
      ex_funct3    <= if_instr[14:12];
      ex_funct7    <= if_instr[31:25];
      ex_writes_rd <= dec_writes_rd;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
Instruction decode/issue stage that sits directly upstream of register_file. It accepts one 32-bit RV32I instruction per cycle from fetch and drives the register-file read addresses. It captures rd1/rd2 with the decoded fields into an ID/EX pipeline register toward execute. A 32-entry pending-write scoreboard stalls issue on RAW hazards until writeback has committed the value to the register file.

Parameters:
regNum, 32, number of architectural registers; index width RW = $clog2(regNum)
regSize, 32, register/data width in bits
instrSize, 32, instruction width (fixed RV32I encoding)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
if_valid  in  1  fetch presents an instruction
if_instr  in  instrSize  instruction word
if_pc  in  regSize  PC of if_instr
if_ready  out  1  stage accepts if_instr this cycle
rf_read_reg_1  out  RW  to register_file read_reg_1 = if_instr[19:15]
rf_read_reg_2  out  RW  to register_file read_reg_2 = if_instr[24:20]
rf_rd1  in  regSize  from register_file rd1
rf_rd2  in  regSize  from register_file rd2
wb_valid  in  1  writeback commits wb_reg this cycle (same cycle as register_file reg_write)
wb_reg  in  RW  destination being written back
flush  in  1  kill the held and the incoming instruction (taken branch from execute)
ex_valid  out  1  ID/EX register holds a valid instruction
ex_ready  in  1  execute consumes ID/EX this cycle
ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  regSize each  PC, operands, sign-extended immediate
ex_rd  out  RW  destination register
ex_opcode  out  7  opcode
ex_funct3  out  3  funct3
ex_funct7  out  7  funct7
ex_writes_rd  out  1  instruction writes rd and rd!=0

Behaviour:
- Reset (async): ex_valid=0, all ex_* data=0, scoreboard=0. if_ready is combinational and follows its equation below.
- rf_read_reg_1/2 are combinational slices of if_instr, so operands are valid in the same cycle.
- Source use by opcode: rs1 for I/S/B/R/JALR; rs2 for S/B/R; none for LUI/AUIPC/JAL. Register x0 is never a hazard.
- hazard = (uses_rs1 && sb[rs1]) || (uses_rs2 && sb[rs2]).
- if_ready = (!ex_valid || ex_ready) && !hazard && !flush.
- accept = if_valid && if_ready. On accept, the ID/EX register loads pc, rf_rd1/rf_rd2, the decoded immediate, fields and writes_rd. ex_valid=1 at the next edge, giving 1-cycle latency.
- If ex_ready && !accept, ex_valid goes to 0. If !ex_ready, the ID/EX contents hold stable (valid/ready: no change while valid && !ready).
- Immediate formats: I, S, B (bit0=0), U (low 12 = 0), J (bit0=0), all sign-extended to regSize. R-type imm = 0. Unknown opcode: ex_writes_rd=0, imm=0, no sources, passed through.
- Scoreboard set: on accept with writes_rd, sb[rd] is set at the edge.
- Scoreboard clear: wb_valid clears sb[wb_reg] at the edge. wb_reg=0 has no effect.
- Same-edge set and clear of the same index: set wins (the new writer is younger).
- No writeback bypass. A reader stays stalled during the wb cycle and issues the cycle after, when the register file holds the new value.
- Flush: at the edge, ex_valid=0 and nothing is accepted that cycle. If ex_valid && !ex_ready, sb[ex_rd] is cleared, since the killed writer never writes back. Instructions already handed to execute are older and still clear their bits via wb.
- Flush and wb on the same cycle are both applied.
- Back-to-back independent instructions sustain 1 per cycle while ex_ready=1.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG), an immediate-format enum (FMT_R/I/S/B/U/J/NONE) and the RW constant.
- Sub-module imm_gen: combinational instruction-to-{format, imm, uses_rs1, uses_rs2, writes_rd}, reusable by verification models.
- Scoreboard and the ID/EX register stay in the top module.

Test Plan:
- rst asserted mid-stream with ex_valid=1 -> ex_valid=0 immediately (async), scoreboard cleared, first instruction after release issues without stall.
- ADDI x5,x0,7 (0x00700293) then ADD x6,x5,x5 back-to-back -> ADD sees if_ready=0. wb_valid with wb_reg=5 in cycle N -> ADD accepted in N+1 with rd1/rd2 from the updated file, ex_imm=0.
- BEQ with imm -4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC, ex_writes_rd=0, scoreboard unchanged. LUI x1,0x12345 -> ex_imm=0x12345000, no source stall even with sb[x0..x31] pending.
- ex_ready held 0 for 3 cycles with ex_valid=1 -> all ex_* outputs stable, if_ready=0. Release -> next instruction issues with 1-cycle latency.
- ADDI x9 held (ex_ready=0) plus flush -> ex_valid=0, sb[9]=0. A following reader of x9 issues with no stall.
- Same-cycle wb_reg=3 and accept of a writer to x3 -> sb[3]=1 afterward.
